// File: rtl/clock_ctrl_pkg.sv
// Shared types, digit layout and BCD helpers for the clock time-set controller.
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_SEC  = 3'd3,
    ST_COMMIT   = 3'd4
  } state_e;

  localparam logic [3:0] HOUR_MAX_10   = 4'd2;
  localparam logic [3:0] HOUR_MAX_1    = 4'd3;
  localparam logic [3:0] MINSEC_MAX_10 = 4'd5;
  localparam logic [3:0] BCD_MAX       = 4'd9;

  // Digit positions inside the 24-bit {h10, h1, m10, m1, s10, s1} vectors.
  localparam int H10_LSB  = 20;
  localparam int H1_LSB   = 16;
  localparam int M10_LSB  = 12;
  localparam int M1_LSB   = 8;
  localparam int S10_LSB  = 4;
  localparam int S1_LSB   = 0;
  localparam int HOUR_LSB = H1_LSB;
  localparam int MIN_LSB  = M1_LSB;
  localparam int SEC_LSB  = S1_LSB;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    logic [3:0] r;
    if (d > BCD_MAX) begin
      r = 4'd0;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // One BCD step of a two-digit field with wrap between 00 and {max10,max1}.
  function automatic logic [7:0] bcd_step(input logic [7:0] fld, input logic up,
                                          input logic [3:0] max10, input logic [3:0] max1);
    logic [3:0] t;
    logic [3:0] o;
    logic [7:0] r;
    t = fld[7:4];
    o = fld[3:0];
    if (up) begin
      if ((t == max10) && (o == max1)) begin
        r = 8'h00;
      end else if (o == BCD_MAX) begin
        r = {t + 4'd1, 4'd0};
      end else begin
        r = {t, o + 4'd1};
      end
    end else begin
      if ((t == 4'd0) && (o == 4'd0)) begin
        r = {max10, max1};
      end else if (o == 4'd0) begin
        r = {t - 4'd1, BCD_MAX};
      end else begin
        r = {t, o - 4'd1};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer and debouncer; emits a one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          level_seen_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Accept a new level only after an unbroken run of differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = {CW{1'b0}};
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Synchronizer, debounce state and registered press pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_seen_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= {CW{1'b0}};
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_seen_q <= level_q;
      press_q      <= level_q & ~level_seen_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-time session controller: freeze, edit h/m/s in BCD, commit with a one-cycle load.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int BLINK_HALF_CYCLES = 6250000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_cancel,
  input  logic [3:0]  cnt_hour10,
  input  logic [3:0]  cnt_hour1,
  input  logic [3:0]  cnt_min10,
  input  logic [3:0]  cnt_min1,
  input  logic [3:0]  cnt_sec10,
  input  logic [3:0]  cnt_sec1,
  output logic        run_en,
  output logic        set_load,
  output logic [23:0] set_time,
  output logic [23:0] disp_time,
  output logic [5:0]  blank_mask,
  output logic        editing
);

  localparam int BW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);

  logic mode_p, up_p, down_p, cancel_p;
  logic adj_up_s, adj_dn_s;

  state_e        state_q, state_d;
  logic [23:0]   edit_q, edit_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          run_en_q, run_en_d;
  logic          set_load_q, set_load_d;
  logic          editing_q, editing_d;
  logic [5:0]    blank_q, blank_d;
  logic [7:0]    field_s, step_s;
  logic [3:0]    max10_s, max1_s;
  logic [23:0]   live_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .resetn(resetn), .btn_i(btn_mode), .press_o(mode_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .resetn(resetn), .btn_i(btn_up), .press_o(up_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .resetn(resetn), .btn_i(btn_down), .press_o(down_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
    .clk(clk), .resetn(resetn), .btn_i(btn_cancel), .press_o(cancel_p));

  assign live_s   = {cnt_hour10, cnt_hour1, cnt_min10, cnt_min1, cnt_sec10, cnt_sec1};
  assign adj_up_s = up_p & ~down_p;
  assign adj_dn_s = down_p & ~up_p;

  // Select the field under edit and its wrap limit.
  always_comb begin
    field_s = edit_q[SEC_LSB +: 8];
    max10_s = MINSEC_MAX_10;
    max1_s  = BCD_MAX;
    case (state_q)
      ST_SET_HOUR: begin
        field_s = edit_q[HOUR_LSB +: 8];
        max10_s = HOUR_MAX_10;
        max1_s  = HOUR_MAX_1;
      end
      ST_SET_MIN: begin
        field_s = edit_q[MIN_LSB +: 8];
        max10_s = MINSEC_MAX_10;
        max1_s  = BCD_MAX;
      end
      default: begin
        field_s = edit_q[SEC_LSB +: 8];
        max10_s = MINSEC_MAX_10;
        max1_s  = BCD_MAX;
      end
    endcase
    step_s = bcd_step(field_s, adj_up_s, max10_s, max1_s);
  end

  // Session FSM and edit registers; cancel beats mode beats up/down.
  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    case (state_q)
      ST_RUN: begin
        if (mode_p) begin
          state_d = ST_SET_HOUR;
          edit_d  = {bcd_clamp(cnt_hour10), bcd_clamp(cnt_hour1),
                     bcd_clamp(cnt_min10),  bcd_clamp(cnt_min1),
                     bcd_clamp(cnt_sec10),  bcd_clamp(cnt_sec1)};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
        if (cancel_p) begin
          state_d = ST_RUN;
        end else if (mode_p) begin
          case (state_q)
            ST_SET_HOUR: state_d = ST_SET_MIN;
            ST_SET_MIN:  state_d = ST_SET_SEC;
            default:     state_d = ST_COMMIT;
          endcase
        end else if (adj_up_s || adj_dn_s) begin
          case (state_q)
            ST_SET_HOUR: edit_d[HOUR_LSB +: 8] = step_s;
            ST_SET_MIN:  edit_d[MIN_LSB +: 8]  = step_s;
            default:     edit_d[SEC_LSB +: 8]  = step_s;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Next-state view of the outputs so they can be registered without extra latency.
  always_comb begin
    editing_d  = (state_d == ST_SET_HOUR) || (state_d == ST_SET_MIN) || (state_d == ST_SET_SEC);
    run_en_d   = (state_d == ST_RUN);
    set_load_d = (state_d == ST_COMMIT);
    if (!editing_d || (state_d != state_q)) begin
      blink_cnt_d = {BW{1'b0}};
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = {BW{1'b0}};
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + {{(BW-1){1'b0}}, 1'b1};
      phase_d     = phase_q;
    end
    blank_d = 6'b000000;
    if (phase_d) begin
      case (state_d)
        ST_SET_HOUR: blank_d = 6'b110000;
        ST_SET_MIN:  blank_d = 6'b001100;
        ST_SET_SEC:  blank_d = 6'b000011;
        default:     blank_d = 6'b000000;
      endcase
    end else begin
      blank_d = 6'b000000;
    end
  end

  // State, edit copy, blink phase and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RUN;
      edit_q      <= 24'h000000;
      blink_cnt_q <= {BW{1'b0}};
      phase_q     <= 1'b0;
      run_en_q    <= 1'b1;
      set_load_q  <= 1'b0;
      editing_q   <= 1'b0;
      blank_q     <= 6'b000000;
    end else begin
      state_q     <= state_d;
      edit_q      <= edit_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      run_en_q    <= run_en_d;
      set_load_q  <= set_load_d;
      editing_q   <= editing_d;
      blank_q     <= blank_d;
    end
  end

  assign run_en     = run_en_q;
  assign set_load   = set_load_q;
  assign editing    = editing_q;
  assign blank_mask = blank_q;
  assign set_time   = edit_q;
  assign disp_time  = (state_q == ST_RUN) ? live_s : edit_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl with short debounce and blink periods.
module tb_clock_set_ctrl;

  localparam int DEB   = 4;
  localparam int BLINK = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_cancel = 1'b0;
  logic [3:0]  cnt_hour10, cnt_hour1, cnt_min10, cnt_min1, cnt_sec10, cnt_sec1;
  logic        run_en, set_load, editing;
  logic [23:0] set_time, disp_time;
  logic [5:0]  blank_mask;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          loads_seen = 0;
  logic        after_load = 1'b0;
  logic [23:0] load_q[$];
  logic [23:0] disp_q[$];
  int          hh, mm, ss;

  always #20 clk = ~clk;

  clock_set_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_HALF_CYCLES(BLINK)) dut (
    .clk(clk), .resetn(resetn),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_cancel(btn_cancel),
    .cnt_hour10(cnt_hour10), .cnt_hour1(cnt_hour1), .cnt_min10(cnt_min10),
    .cnt_min1(cnt_min1), .cnt_sec10(cnt_sec10), .cnt_sec1(cnt_sec1),
    .run_en(run_en), .set_load(set_load), .set_time(set_time),
    .disp_time(disp_time), .blank_mask(blank_mask), .editing(editing)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bcd6(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic set_live(input logic [23:0] v);
    {cnt_hour10, cnt_hour1, cnt_min10, cnt_min1, cnt_sec10, cnt_sec1} = v;
  endtask

  task automatic press(input logic m, input logic u, input logic d, input logic c);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d; btn_cancel = c;
    repeat (DEB + 6) @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_cancel = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic press_expect(input string tag, input logic m, input logic u, input logic d,
                              input logic c, input logic [23:0] exp_disp, input logic exp_edit);
    disp_q.push_back(exp_disp);
    press(m, u, d, c);
    check_val(tag, disp_time, disp_q.pop_front());
    check_val({tag, "_editing"}, editing, exp_edit);
  endtask

  // Load scoreboard plus run_en freeze watch.
  always @(negedge clk) begin
    if (after_load) begin
      check_val("run_en_after_load", run_en, 1);
      check_val("load_one_cycle", set_load, 0);
    end
    after_load = resetn && set_load;
    if (resetn && set_load) begin
      loads_seen++;
      check_val("run_en_during_load", run_en, 0);
      if (load_q.size() == 0) check_val("unexpected_load", 1, 0);
      else check_val("set_time_at_load", set_time, load_q.pop_front());
    end
    if (resetn && editing) check_val("run_en_while_editing", run_en, 0);
  end

  initial begin
    int k;
    set_live(24'h124559);
    repeat (3) @(negedge clk);
    check_val("rst_run_en", run_en, 1);
    check_val("rst_set_load", set_load, 0);
    check_val("rst_set_time", set_time, 0);
    check_val("rst_blank", blank_mask, 0);
    check_val("rst_editing", editing, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check_val("run_disp", disp_time, 24'h124559);
    set_live(24'h134507);
    @(negedge clk);
    check_val("run_disp_follow", disp_time, 24'h134507);

    // Enter SET_HOUR and watch the first two blink phases.
    btn_mode = 1'b1;
    k = 0;
    while (!editing && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_val("enter_set_hour", editing, 1);
    for (int i = 0; i < 17; i++) begin
      if (i == 0 || i == 7 || i == 16) check_val("blink_phase0", blank_mask, 6'h00);
      if (i == 8 || i == 15) check_val("blink_phase1", blank_mask, 6'h30);
      @(negedge clk);
    end
    btn_mode = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    check_val("capture_disp", disp_time, 24'h134507);
    check_val("set_run_en", run_en, 0);
    hh = 13; mm = 45; ss = 7;
    set_live(24'h111111);

    for (int i = 0; i < 11; i++) begin
      hh = (hh + 1) % 24;
      press_expect("hour_up", 1'b0, 1'b1, 1'b0, 1'b0, bcd6(hh, mm, ss), 1'b1);
    end

    @(negedge clk);
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    btn_up = 1'b0;
    repeat (DEB + 8) @(negedge clk);
    check_val("glitch_ignored", disp_time, bcd6(hh, mm, ss));

    hh = (hh + 23) % 24;
    press_expect("hour_down_wrap", 1'b0, 1'b0, 1'b1, 1'b0, bcd6(hh, mm, ss), 1'b1);
    press_expect("to_set_min", 1'b1, 1'b0, 1'b0, 1'b0, bcd6(hh, mm, ss), 1'b1);

    for (int i = 0; i < 15; i++) begin
      mm = (mm + 1) % 60;
      press_expect("min_up", 1'b0, 1'b1, 1'b0, 1'b0, bcd6(hh, mm, ss), 1'b1);
    end
    mm = (mm + 59) % 60;
    press_expect("min_down_wrap", 1'b0, 1'b0, 1'b1, 1'b0, bcd6(hh, mm, ss), 1'b1);
    for (int i = 0; i < 2; i++) begin
      mm = (mm + 1) % 60;
      press_expect("min_up_wrap", 1'b0, 1'b1, 1'b0, 1'b0, bcd6(hh, mm, ss), 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      mm = (mm + 59) % 60;
      press_expect("min_down", 1'b0, 1'b0, 1'b1, 1'b0, bcd6(hh, mm, ss), 1'b1);
    end
    press_expect("up_down_both", 1'b0, 1'b1, 1'b1, 1'b0, bcd6(hh, mm, ss), 1'b1);
    press_expect("mode_and_up", 1'b1, 1'b1, 1'b0, 1'b0, bcd6(hh, mm, ss), 1'b1);
    for (int i = 0; i < 9; i++) begin
      ss = (ss + 59) % 60;
      press_expect("sec_down", 1'b0, 1'b0, 1'b1, 1'b0, bcd6(hh, mm, ss), 1'b1);
    end
    load_q.push_back(24'h235958);
    press_expect("commit", 1'b1, 1'b0, 1'b0, 1'b0, 24'h111111, 1'b0);
    check_val("commit_run_en", run_en, 1);
    check_val("commit_set_time", set_time, 24'h235958);

    set_live(24'h010203);
    press_expect("c_hour", 1'b1, 1'b0, 1'b0, 1'b0, 24'h010203, 1'b1);
    press_expect("c_min", 1'b1, 1'b0, 1'b0, 1'b0, 24'h010203, 1'b1);
    press_expect("c_sec", 1'b1, 1'b0, 1'b0, 1'b0, 24'h010203, 1'b1);
    press_expect("c_sec_up", 1'b0, 1'b1, 1'b0, 1'b0, 24'h010204, 1'b1);
    press_expect("cancel", 1'b0, 1'b0, 1'b0, 1'b1, 24'h010203, 1'b0);
    check_val("cancel_run_en", run_en, 1);
    check_val("cancel_blank", blank_mask, 0);

    set_live(24'h2A5F3B);
    press_expect("capture_clamp", 1'b1, 1'b0, 1'b0, 1'b0, 24'h205030, 1'b1);
    press_expect("r_min", 1'b1, 1'b0, 1'b0, 1'b0, 24'h205030, 1'b1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_val("mid_rst_run_en", run_en, 1);
    check_val("mid_rst_editing", editing, 0);
    check_val("mid_rst_set_load", set_load, 0);
    check_val("mid_rst_set_time", set_time, 0);
    check_val("mid_rst_blank", blank_mask, 0);
    check_val("mid_rst_disp", disp_time, 24'h2A5F3B);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    check_val("post_rst_editing", editing, 0);

    check_val("load_count", loads_seen, 1);
    check_val("load_queue_empty", load_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-set controller for the 25 MHz digital clock. It sits between the board push-buttons and the `clk_divider` time counters, and sequences a set-time session: freeze, edit hours, edit minutes, edit seconds, commit. It debounces the buttons, holds an editable BCD copy of the time, and issues a one-cycle load to the counters. It also drives the digits and blink mask that the segment and text formatters display.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000 (20 ms at 25 MHz): consecutive stable samples required to accept a button level.
- `BLINK_HALF_CYCLES`, default 6250000 (2 Hz blink): cycles per blink phase.

Ports:
- `clk`, in, 1: 25 MHz clock. Reset is asynchronous, active-low.
- `resetn`, in, 1: asynchronous active-low reset.
- `btn_mode`, `btn_up`, `btn_down`, `btn_cancel`, in, 1 each: raw active-high buttons, asynchronous to `clk`.
- `cnt_hour10`, `cnt_hour1`, `cnt_min10`, `cnt_min1`, `cnt_sec10`, `cnt_sec1`, in, 4 each: live BCD time from the counters.
- `run_en`, out, 1: counter count-enable.
- `set_load`, out, 1: one-cycle load strobe to the counters.
- `set_time`, out, 24: load value, ordered {h10, h1, m10, m1, s10, s1}.
- `disp_time`, out, 24: digits to display, same order as `set_time`.
- `blank_mask`, out, 6: 1 = blank that digit. Bit 5 = h10, bit 0 = s1.
- `editing`, out, 1: high in any SET state.

## Operation

- Each button passes through a 2-flop synchronizer and then a debouncer. The debouncer accepts a new level after `DEBOUNCE_CYCLES` consecutive equal samples. It emits a 1-cycle `*_press` pulse on each accepted 0→1 transition. Release produces no pulse.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
  - RUN + mode: capture the six `cnt_*` digits into edit registers, go to SET_HOUR. Any captured digit greater than 9 is stored as 0.
  - SET_HOUR → SET_MIN → SET_SEC on mode.
  - SET_SEC + mode → COMMIT.
  - COMMIT → RUN unconditionally after 1 cycle.
  - Any SET state + cancel → RUN. No load is issued and the edit registers are discarded.
- Press priority in the same cycle: cancel > mode > up/down. Up and down together are both ignored. All presses in RUN other than mode are ignored, as are all presses in COMMIT.
- Field arithmetic, in BCD on the field under edit:
  - Hour up: 23 wraps to 00; otherwise x9 → (x+1)0, else ones+1.
  - Hour down: 00 wraps to 23; otherwise x0 → (x−1)9, else ones−1.
  - Minute and second: same rules with 59 ↔ 00.
- `run_en`: 1 in RUN, 0 in SET_* and COMMIT. Counters stay frozen through the load.
- `set_load`: 1 only in COMMIT. `set_time` = edit registers at all times and is stable while `set_load` is high.
- `disp_time`: the live `cnt_*` digits in RUN, the edit registers in SET_* and COMMIT.
- `blank_mask`:
  - The blink phase counter free-runs only while `editing`. It clears to phase 0 on entry to each SET state.
  - During phase 1, the two bits of the edited field are set.
  - The mask is 0 in RUN, in COMMIT, and during phase 0.

## Timing

- Reset values: state RUN, `run_en`=1, `set_load`=0, edit registers and `set_time`=0, `blank_mask`=0, `editing`=0, debouncers at accepted level 0, blink counter 0. `disp_time` follows `cnt_*` from reset.
- Raw button rising and held: `*_press` is high for exactly one cycle, `DEBOUNCE_CYCLES`+3 clocks after the first sampling edge (2 sync + count + pulse register).
- The FSM samples a press in the cycle it is high. The state and edit registers update on the next edge, so the outputs reflect the change 1 cycle after the press.
- COMMIT lasts exactly 1 cycle. `run_en` returns to 1 in the cycle after `set_load`.
- A reset asserted mid-session returns everything to the reset values immediately, with no load. It also clears any in-progress debounce count.
- A pulse shorter than `DEBOUNCE_CYCLES` samples produces no press.

## Structure

- Package `clock_ctrl_pkg` holds:
  - the state enum;
  - constants HOUR_MAX_10=2, HOUR_MAX_1=3, MINSEC_MAX_10=5;
  - the BCD digit-order localparams for the 24-bit vectors.
- Sub-module `btn_debounce` (synchronizer, stable counter, press pulse, parameter `DEBOUNCE_CYCLES`) is instantiated four times.
- The FSM, edit registers, and BCD inc/dec logic live in `clock_set_ctrl`.

## Test plan

Run the bench with `DEBOUNCE_CYCLES`=4 and `BLINK_HALF_CYCLES`=8.
- Reset, no buttons → RUN, `run_en`=1, `set_load`=0, `blank_mask`=0, `disp_time` tracks `cnt_*` (e.g. 0x124559).
- Live time 0x134507, mode press → SET_HOUR, `editing`=1, `run_en`=0, `disp_time`=0x134507. 11 up presses → hour 00 (wrap through 23). Bits 5:4 of `blank_mask` toggle every 8 cycles.
- In SET_MIN with minutes 00, one down → 59. 2 ups → 01.
- Edit to 0x235958, then mode ×3 → `set_load` high for exactly 1 cycle with `set_time`=0x235958, `run_en`=1 on the following cycle. `run_en` stays 0 throughout editing.
- `btn_up` glitch high for 3 cycles in SET_HOUR → no change. Mode and up pressed together → state advances, field unchanged.
- Cancel in SET_SEC → RUN with no `set_load`. Separately, `resetn` low in SET_MIN → reset values immediately, no `set_load`.
